// File: rtl/dot_loader_pkg.sv
// dot_loader_pkg: shared defaults and fill-counter typing for dot_operand_loader
package dot_loader_pkg;
  localparam int DOT_N = 32;
  localparam int DOT_LEN = 4;
  function automatic int cnt_width(int len);
    return $clog2(len + 1);
  endfunction
  localparam int DOT_CW = cnt_width(DOT_LEN);
  typedef logic [DOT_CW-1:0] cnt_t;
endpackage

// File: rtl/dot_operand_loader_if.sv
// dot_operand_loader_if: element-pair input stream and vector-pair output stream
interface dot_operand_loader_if import dot_loader_pkg::*; #(
  parameter int N = DOT_N,
  parameter int LEN = DOT_LEN
);
  logic s_valid;
  logic s_ready;
  logic [N-1:0] s_a;
  logic [N-1:0] s_b;
  logic s_last;
  logic m_valid;
  logic m_ready;
  logic [N-1:0] m_vec_a [LEN-1:0];
  logic [N-1:0] m_vec_b [LEN-1:0];
  modport slave (
    input s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_vec_a, m_vec_b
  );
  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input s_ready, m_valid, m_vec_a, m_vec_b
  );
endinterface

// File: rtl/operand_fill_buf.sv
// operand_fill_buf: indexed-write fill buffer; view shows the vector as it would look after this cycle's write/pad
module operand_fill_buf import dot_loader_pkg::*; #(
  parameter int N = DOT_N,
  parameter int LEN = DOT_LEN,
  localparam int CW = cnt_width(LEN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic pad,
  input  logic [CW-1:0] idx,
  input  logic [N-1:0] din,
  output logic [N-1:0] view [LEN-1:0]
);
  logic [N-1:0] q [LEN-1:0];
  always_ff @(posedge clk)
    if (!rst_n) q <= '{default: '0};
    else
      for (int i = 0; i < LEN; i++)
        if (we && CW'(i) == idx) q[i] <= din;
        else if (pad && CW'(i) > idx) q[i] <= '0;
  // bypass lets the completing element reach the output register in the same edge
  always_comb
    for (int i = 0; i < LEN; i++)
      view[i] = (we && CW'(i) == idx) ? din : (pad && CW'(i) > idx) ? '0 : q[i];
endmodule

// File: rtl/dot_operand_loader.sv
// dot_operand_loader: gathers LEN element pairs into vector pairs for the dot-product unit
// Optional zero-padded short vectors via s_last when DOT_LOADER_PAD_EN is defined.
module dot_operand_loader import dot_loader_pkg::*; #(
  parameter int N = DOT_N,
  parameter int LEN = DOT_LEN
) (
  input logic clk,
  input logic rst_n,
  dot_operand_loader_if.slave s
);
  localparam int CW = cnt_width(LEN);
  localparam logic [CW-1:0] FULL = CW'(LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
  logic [CW-1:0] cnt;
  logic [N-1:0] view_a [LEN-1:0];
  logic [N-1:0] view_b [LEN-1:0];
  logic in_xfer, slot_free, pad_req, pad, last_in, load;
`ifdef DOT_LOADER_PAD_EN
  assign pad_req = s.s_last;
`else
  assign pad_req = 1'b0;
`endif
  assign s.s_ready = cnt != FULL;
  assign in_xfer = s.s_valid && s.s_ready;
  assign slot_free = !s.m_valid || s.m_ready;
  assign pad = in_xfer && pad_req && cnt < LAST_IDX;
  assign last_in = in_xfer && (cnt == LAST_IDX || pad);
  assign load = (last_in || cnt == FULL) && slot_free;
  operand_fill_buf #(.N(N), .LEN(LEN)) u_buf_a (
    .clk, .rst_n, .we(in_xfer), .pad, .idx(cnt), .din(s.s_a), .view(view_a)
  );
  operand_fill_buf #(.N(N), .LEN(LEN)) u_buf_b (
    .clk, .rst_n, .we(in_xfer), .pad, .idx(cnt), .din(s.s_b), .view(view_b)
  );
  // cnt == FULL parks a completed vector while the output slot is occupied
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      s.m_valid <= 1'b0;
      s.m_vec_a <= '{default: '0};
      s.m_vec_b <= '{default: '0};
    end else begin
      cnt <= load ? '0 : last_in ? FULL : in_xfer ? cnt + CW'(1) : cnt;
      s.m_valid <= load || (s.m_valid && !s.m_ready);
      if (load) begin
        s.m_vec_a <= view_a;
        s.m_vec_b <= view_b;
      end
    end
endmodule

// File: tb/tb_dot_operand_loader.sv
// tb_dot_operand_loader: random and directed stimulus against a queue-based vector model
module tb_dot_operand_loader;
  localparam int N = 32;
  localparam int LEN = 4;
`ifdef DOT_LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  typedef logic [N-1:0] vec_t [LEN];
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, failures = 0, delivered = 0, stalls = 0;
  int mode = 0;
  logic rdy = 1'b1;
  vec_t exp_a[$];
  vec_t exp_b[$];
  logic [N-1:0] cur_a[$];
  logic [N-1:0] cur_b[$];
  dot_operand_loader_if #(.N(N), .LEN(LEN)) bus ();
  dot_operand_loader #(.N(N), .LEN(LEN)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_in(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
    vec_t va, vb;
    cur_a.push_back(a);
    cur_b.push_back(b);
    if (cur_a.size() == LEN || (PAD && last)) begin
      for (int i = 0; i < LEN; i++) begin
        va[i] = i < cur_a.size() ? cur_a[i] : '0;
        vb[i] = i < cur_b.size() ? cur_b[i] : '0;
      end
      exp_a.push_back(va);
      exp_b.push_back(vb);
      cur_a.delete();
      cur_b.delete();
    end
  endtask
  // pending completed vectors predict m_valid (>=1) and s_ready (<2) each cycle
  always @(negedge clk) begin
    chk("m_valid", N'(bus.m_valid), N'(exp_a.size() > 0));
    chk("s_ready", N'(bus.s_ready), N'(exp_a.size() < 2));
    if (bus.m_valid && exp_a.size() > 0)
      for (int i = 0; i < LEN; i++) begin
        chk("vec_a", bus.m_vec_a[i], exp_a[0][i]);
        chk("vec_b", bus.m_vec_b[i], exp_b[0][i]);
      end
    if (!rst_n) begin
      exp_a.delete();
      exp_b.delete();
      cur_a.delete();
      cur_b.delete();
    end else begin
      if (bus.m_valid && bus.m_ready && exp_a.size() > 0) begin
        exp_a.delete(0);
        exp_b.delete(0);
        delivered++;
      end
      if (bus.s_valid && bus.s_ready) model_in(bus.s_a, bus.s_b, bus.s_last);
    end
  end
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.m_ready = mode == 1 ? !bus.m_ready : mode == 2 ? 1'($urandom_range(0, 1)) : rdy;
    end
  end
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
    logic hs;
    bus.s_valid = 1'b1;
    bus.s_a = a;
    bus.s_b = b;
    bus.s_last = last;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      hs = bus.s_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      stalls++;
      if (t > 200) begin
        chk("send_timeout", N'(hs), N'(1));
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask
  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain(input string tag);
    for (int t = 0; t < 300 && exp_a.size() != 0; t++) idle(1);
    chk(tag, N'(exp_a.size()), N'(0));
  endtask
  initial begin
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a = '0;
    bus.s_b = '0;
    bus.s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(N'(i + 1), N'(i + 5), 1'b0);
    idle(3);
    chk("p1_count", N'(delivered), N'(1));
    for (int i = 0; i < 12; i++) send(N'(100 + i), N'(200 + i), 1'b0);
    idle(3);
    chk("p2_count", N'(delivered), N'(4));
    chk("p2_stalls", N'(stalls), N'(0));
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(N'(300 + i), N'(400 + i), 1'b0);
    idle(4);
    chk("p3_held", N'(delivered), N'(4));
    chk("p3_full", N'(bus.s_ready), N'(0));
    rdy = 1'b1;
    drain("p3_drain");
    chk("p3_count", N'(delivered), N'(6));
    send(N'(50), N'(60), 1'b0);
    send(N'(51), N'(61), 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(N'(9 + i), N'(29 + i), 1'b0);
    drain("p4_drain");
    chk("p4_count", N'(delivered), N'(7));
    send(N'(7), N'(17), 1'b0);
    send(N'(8), N'(18), 1'b1);
    idle(3);
    chk("pad_first", N'(delivered), PAD ? N'(8) : N'(7));
    send(N'(13), N'(23), 1'b0);
    send(N'(14), N'(24), 1'b1);
    drain("pad_drain");
    chk("pad_count", N'(delivered), PAD ? N'(9) : N'(8));
    mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send($urandom, $urandom, i == 399 || $urandom_range(0, 7) == 0);
    end
    drain("p5_drain");
    mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send($urandom, $urandom, i == 199 || $urandom_range(0, 5) == 0);
    end
    mode = 0;
    rdy = 1'b1;
    drain("p6_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
